// File: rtl/io_irq_ctrl_if.sv
// rtl/io_irq_ctrl_if.sv - register, input-port and interrupt signal bundle for io_irq_ctrl
interface io_irq_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int N_PORTS = 4
);
    logic                      out_we;
    logic [2:0]                out_sel;
    logic [DATA_W-1:0]         out_data;
    logic [N_PORTS*DATA_W-1:0] reg_out;
    logic [N_PORTS*DATA_W-1:0] in_port;
    logic [2:0]                in_sel;
    logic [DATA_W-1:0]         in_data;
    logic [N_PORTS-1:0]        ie;
    logic                      mask_we;
    logic [N_PORTS-1:0]        mask_data;
    logic                      irq;
    logic [2:0]                irq_vec;
    logic                      irq_ack;
    logic                      irq_done;
    logic                      in_service;

    modport master (
        output out_we, out_sel, out_data, in_port, in_sel, ie,
               mask_we, mask_data, irq_ack, irq_done,
        input  reg_out, in_data, irq, irq_vec, in_service
    );

    modport slave (
        input  out_we, out_sel, out_data, in_port, in_sel, ie,
               mask_we, mask_data, irq_ack, irq_done,
        output reg_out, in_data, irq, irq_vec, in_service
    );
endinterface

// File: rtl/io_irq_ctrl.sv
// rtl/io_irq_ctrl.sv - IO registers with edge-triggered, masked, priority interrupt controller (optional IO_IRQ_SYNC_EN)
module io_irq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int N_PORTS = 4
) (
    input logic         clk,
    input logic         reset,
    io_irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [N_PORTS-1:0][DATA_W-1:0] r_reg_out;
    logic [DATA_W-1:0]              w_in_data;
    logic [N_PORTS-1:0]             w_ie_s;
    logic [N_PORTS-1:0]             r_ie_q;
    logic [N_PORTS-1:0]             w_rise;
    logic [N_PORTS-1:0]             r_pending;
    logic [N_PORTS-1:0]             r_mask;
    logic [N_PORTS-1:0]             w_req;
    logic [N_PORTS-1:0]             w_clr;
    logic [2:0]                     w_low_idx;
    logic [2:0]                     r_irq_vec;
    state_t                         r_state;
    state_t                         w_next;
    logic                           w_irq;
    logic                           w_in_service;

    // Output registers: addressed write; indices with no register are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_out <= '0;
        end else if (bus.out_we) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (bus.out_sel == 3'(i)) begin
                    r_reg_out[i] <= bus.out_data;
                end
            end
        end
    end

    assign bus.reg_out = r_reg_out;

    // Input port read mux; out-of-range index reads as zero
    always_comb begin
        w_in_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (bus.in_sel == 3'(i)) begin
                w_in_data = bus.in_port[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.in_data = w_in_data;

`ifdef IO_IRQ_SYNC_EN
    logic [N_PORTS-1:0] r_sync1;
    logic [N_PORTS-1:0] r_sync2;

    // Two-flop synchroniser for asynchronous interrupt lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.ie;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ie_s = r_sync2;
`else
    assign w_ie_s = bus.ie;
`endif

    // Previous-sample register; cleared by reset so a line held high produces an edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie_q <= '0;
        end else begin
            r_ie_q <= w_ie_s;
        end
    end

    assign w_rise = w_ie_s & ~r_ie_q;

    // Acknowledge clears only the committed vector's pending bit
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if ((r_state == ST_REQ) && bus.irq_ack && (r_irq_vec == 3'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    // Pending bits: a new edge outranks a same-cycle acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Mask register; it gates arbitration only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_data;
        end
    end

    assign w_req = r_pending & r_mask;

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        w_low_idx = 3'd0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // Vector is captured on leaving IDLE and held through REQ and SERVICE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_vec <= 3'd0;
        end else if ((r_state == ST_IDLE) && (w_req != '0)) begin
            r_irq_vec <= w_low_idx;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and outputs; stray ack/done in other states fall through to hold
    always_comb begin
        w_next       = r_state;
        w_irq        = 1'b0;
        w_in_service = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req != '0) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_irq = 1'b1;
                if (bus.irq_ack) begin
                    w_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                w_in_service = 1'b1;
                if (bus.irq_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.irq        = w_irq;
    assign bus.irq_vec    = r_irq_vec;
    assign bus.in_service = w_in_service;
endmodule
